uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between N_REQ byte producers.
- Each requester has a valid/ready byte interface. The arbiter picks a requester round-robin, drives the transmitter's din/enable, then waits for its done before the next grant.
- Sits between the producer blocks and the UART TX top.
- Adds an inter-frame gap and a done-timeout watchdog so a hung transmitter cannot stall the system.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with an inter-frame gap and a done-timeout watchdog; all outputs registered.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1,
  localparam int GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         tx_din,
  output logic                      tx_enable,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   sel;
  logic              sel_vld;
  logic [CNT_W-1:0]  wd_cnt, wd_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              done_q, done_rise;
  logic [N_REQ-1:0]  ready_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic [ID_W-1:0]   gid_nxt;
  logic              enable_nxt, terr_nxt;

  assign done_rise = tx_done & ~done_q;

  // Scan downward so the lowest offset from the pointer is the last (winning) hit.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      idx = (int'(ptr) + o) % N_REQ;
      if (req_valid[idx]) begin
        sel     = ID_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    din_nxt     = tx_din;
    gid_nxt     = grant_id;
    enable_nxt  = 1'b0;
    ready_nxt   = '0;
    terr_nxt    = 1'b0;
    wd_cnt_nxt  = wd_cnt;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt      = LAUNCH;
          din_nxt        = req_data[int'(sel)*DATA_W +: DATA_W];
          gid_nxt        = sel;
          ptr_nxt        = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
          enable_nxt     = 1'b1;
          ready_nxt[sel] = 1'b1;
          wd_cnt_nxt     = '0;
        end
      end
      // The enable cycle counts toward the budget, so timeout_err lands
      // TIMEOUT_CYC-1 cycles after tx_enable.
      LAUNCH: begin
        state_nxt  = WAIT_DONE;
        wd_cnt_nxt = wd_cnt + 1'b1;
      end
      WAIT_DONE: begin
        wd_cnt_nxt = wd_cnt + 1'b1;
        if (done_rise) begin
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYC == 0) ? IDLE : GAP;
        end else if (int'(wd_cnt_nxt) >= TIMEOUT_CYC - 1) begin
          terr_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (int'(gap_cnt) >= GAP_CYC - 1) state_nxt = IDLE;
        else                              gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      done_q      <= 1'b0;
      req_ready   <= '0;
      tx_din      <= '0;
      tx_enable   <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      wd_cnt      <= wd_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      done_q      <= tx_done;
      req_ready   <= ready_nxt;
      tx_din      <= din_nxt;
      tx_enable   <= enable_nxt;
      grant_id    <= gid_nxt;
      busy        <= (state_nxt != IDLE);
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a transaction-level
// round-robin / timing model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int GP = 3;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_din;
  logic           tx_enable;
  logic           tx_done = 1'b0;
  logic [1:0]     grant_id;
  logic           busy, timeout_err;

  logic [N-1:0]   z_valid = '0;
  logic [N*W-1:0] z_data = '0;
  logic [N-1:0]   z_ready;
  logic [W-1:0]   z_din;
  logic           z_enable;
  logic           z_done = 1'b0;
  logic [1:0]     z_gid;
  logic           z_busy, z_terr;

  int checks = 0;
  int errors = 0;

  bit          pend[N];
  logic [7:0]  pdata[N];
  int          ptr = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYC(GP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_din(tx_din), .tx_enable(tx_enable), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYC(0), .TIMEOUT_CYC(TO)) dut_ng (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_data(z_data),
    .req_ready(z_ready), .tx_din(z_din), .tx_enable(z_enable), .tx_done(z_done),
    .grant_id(z_gid), .busy(z_busy), .timeout_err(z_terr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_data[i*W +: W] = pdata[i];
    end
  endtask

  function automatic int pick();
    for (int o = 0; o < N; o++)
      if (pend[(ptr + o) % N]) return (ptr + o) % N;
    return -1;
  endfunction

  // Wait for the launch and check it against the round-robin choice.
  task automatic await_launch(output int g, output int lat);
    g   = pick();
    lat = 0;
    while (!tx_enable && lat < 100) begin
      tick();
      lat++;
    end
    chk("launch_seen", tx_enable, 1);
    chk("tx_din", tx_din, pdata[g]);
    chk("req_ready", req_ready, 32'(1) << g);
    chk("grant_id", grant_id, g);
    chk("busy_launch", busy, 1);
    ptr = (g + 1) % N;
  endtask

  // Drive done (pulse, or level when hold=1) and check timeout/busy timing.
  task automatic finish(input int g, input int dly, input bit hold, input bit rearm, input bit add);
    int fin, r;
    bit done_ok;
    logic [7:0] d0;
    d0      = pdata[g];
    done_ok = (dly >= 1 && dly <= TO - 2);
    fin     = done_ok ? dly + GP + 1 : TO - 1;
    for (int k = 1; k <= fin; k++) begin
      tick();
      if (k == 1) begin
        if (rearm) pdata[g] = 8'($urandom);
        else       pend[g]  = 1'b0;
        drive();
      end
      if (add && k == 2) begin
        r = $urandom_range(0, N - 1);
        if (!pend[r]) begin
          pend[r]  = 1'b1;
          pdata[r] = 8'($urandom);
        end
        drive();
      end
      if (hold) begin
        if (dly != 0 && k == dly - 1) tx_done = 1'b0;
        if (dly != 0 && k == dly)     tx_done = 1'b1;
      end else begin
        tx_done = (k == dly);
      end
      chk("timeout_err", timeout_err, (!done_ok && k == fin));
      chk("enable_low", tx_enable, 0);
      chk("busy", busy, (k < fin));
      chk("din_hold", tx_din, d0);
    end
  endtask

  task automatic frame(input int dly, input bit hold, input bit rearm, input bit add,
                       output int g, output int lat);
    await_launch(g, lat);
    finish(g, dly, hold, rearm, add);
  endtask

  always @(posedge clk) begin
    #1;
    checks++;
    assert ($onehot0(req_ready) && (tx_enable == (req_ready != '0))) else begin
      errors++;
      $error("FAIL ready_onehot observed=%0h/%0b expected=onehot_with_enable", req_ready, tx_enable);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int g, lat;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
    end
    // Reset
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_enable", tx_enable, 0);
    chk("rst_din", tx_din, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_z_busy", z_busy, 0);

    // Single request, first-launch latency
    pend[0] = 1'b1; pdata[0] = 8'hF1; drive();
    rst = 1'b1;
    frame(40, 0, 0, 0, g, lat);
    chk("single_lat", lat, 1);

    // Round robin with all requesters continuously valid
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pdata[i] = 8'(8'h10 + i);
    end
    drive();
    for (int i = 0; i < 5; i++) begin
      await_launch(g, lat);
      chk("rr_lat", lat, 1);
      chk("rr_din", tx_din, 8'h10 + ((1 + i) % N));
      pdata[g] = tx_din;
      finish(g, $urandom_range(1, TO - 2), 0, 0, 0);
      pend[g] = 1'b1; drive();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    tick();

    // Pointer wrap: serve 2, then 0 and 1 pending
    pend[2] = 1'b1; pdata[2] = 8'h22; drive();
    frame(7, 0, 0, 0, g, lat);
    pend[0] = 1'b1; pdata[0] = 8'hA0; pend[1] = 1'b1; pdata[1] = 8'hA1; drive();
    frame(5, 0, 0, 0, g, lat);
    chk("wrap_first", g, 0);
    frame(5, 0, 0, 0, g, lat);
    chk("wrap_second", g, 1);

    // Timeout, then the other pending requester is served
    pend[3] = 1'b1; pdata[3] = 8'h33; pend[1] = 1'b1; pdata[1] = 8'h31; drive();
    frame(0, 0, 0, 0, g, lat);
    chk("to_grant", g, 3);
    frame(20, 0, 0, 0, g, lat);
    chk("after_to_grant", g, 1);
    chk("after_to_lat", lat, 1);

    // Done on the final watchdog cycle wins over the timeout
    pend[0] = 1'b1; pdata[0] = 8'h5C; drive();
    frame(TO - 2, 0, 0, 0, g, lat);

    // tx_done held high: no edge -> timeout; fresh edge -> completion
    tx_done = 1'b1;
    tick();
    pend[2] = 1'b1; pdata[2] = 8'hC2; drive();
    frame(0, 1, 0, 0, g, lat);
    pend[0] = 1'b1; pdata[0] = 8'hC0; drive();
    frame(10, 1, 0, 0, g, lat);
    tx_done = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      if (pick() < 0) begin
        g = $urandom_range(0, N - 1);
        pend[g] = 1'b1; pdata[g] = 8'($urandom); drive();
      end
      frame(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO - 2), 0,
            1'($urandom_range(0, 1)), 1, g, lat);
      chk("rand_lat", lat, 1);
    end

    // Reset during WAIT_DONE
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    repeat (2) tick();
    pend[2] = 1'b1; pdata[2] = 8'h77; drive();
    await_launch(g, lat);
    tick();
    pend[2] = 1'b0; pend[1] = 1'b1; pdata[1] = 8'h61; pend[3] = 1'b1; pdata[3] = 8'h63; drive();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_enable", tx_enable, 0);
    chk("mid_rst_din", tx_din, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    rst = 1'b1;
    ptr = 0;
    frame(9, 0, 0, 0, g, lat);
    chk("post_rst_grant", g, 1);

    // GAP_CYC=0: launch two cycles after done_rise
    z_valid = 4'b0001; z_data[7:0] = 8'hA5;
    tick();
    chk("z_enable", z_enable, 1);
    chk("z_din", z_din, 8'hA5);
    tick();
    z_valid = 4'b0100; z_data[23:16] = 8'h5A;
    repeat (2) tick();
    z_done = 1'b1;
    tick();
    z_done = 1'b0;
    chk("z_busy_after_done", z_busy, 0);
    chk("z_enable_d1", z_enable, 0);
    tick();
    chk("z_enable_d2", z_enable, 1);
    chk("z_din2", z_din, 8'h5A);
    chk("z_gid2", z_gid, 2);
    z_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
